raman_trace_accum: RTL and testbench

Parametrised multi-channel trace accumulator for the Raman DTS acquisition chain.
- Per measurement sequence it captures `n_meas` triggered traces of `POINTS` ADC samples on `CH` parallel channels (stokes, antistokes, …).
- Each point is summed into internal RAM by read-modify-write.
- The sums are then streamed out over a valid/ready port to the ratio/division stage.
- It generalises the fixed 2-channel, fixed-depth accumulator: parameterised width, depth and channel count, plus missed-trigger detection and back-pressured readout.

---
 rtl/raman_trace_accum.sv | 251 +++++++++++++++++++++++++
 tb/tb_raman_trace_accum.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/raman_trace_accum.sv
// raman_trace_accum
// Multi-channel trace accumulator for the Raman DTS acquisition chain.
// A sequence captures n_meas triggered traces of POINTS samples on CH
// channels, sums each point into RAM by read-modify-write, then streams
// the sums out over a valid/ready port with a 2-entry skid buffer.
//
// Optional feature macro: RAMAN_ACC_SATURATE_EN
//   defined   -> per-channel sums clamp at 2^ACC_W-1, sat_flag sticky on clamp
//   undefined -> sums wrap modulo 2^ACC_W, sat_flag tied low
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   start, n_meas     begin a sequence (IDLE only), traces per sequence (0 -> 1)
//   enable            trace trigger, level sampled in ARM
//   data              CH unsigned samples, channel c at [c*DATA_W +: DATA_W]
//   busy, ready       not-IDLE indicator, 1-cycle pulse after final readout
//   cnt_measure       traces completed in the current sequence
//   cnt_point         index of the sample being captured
//   trig_miss         sticky: enable seen during ACQ
//   q, q_valid, q_ready, q_point, q_last   readout stream
//   sat_flag          sticky saturation indicator
module raman_trace_accum #(
    parameter int DATA_W  = 12,
    parameter int CH      = 2,
    parameter int POINTS  = 1500,
    parameter int ACC_W   = 29,
    parameter int NMEAS_W = 17,
    parameter int PT_W    = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [NMEAS_W-1:0]    n_meas,
    input  logic                  enable,
    input  logic [CH*DATA_W-1:0]  data,
    output logic                  busy,
    output logic                  ready,
    output logic [NMEAS_W-1:0]    cnt_measure,
    output logic [PT_W-1:0]       cnt_point,
    output logic                  trig_miss,
    output logic [CH*ACC_W-1:0]   q,
    output logic                  q_valid,
    input  logic                  q_ready,
    output logic [PT_W-1:0]       q_point,
    output logic                  q_last,
    output logic                  sat_flag
);

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_ACQ, S_WB, S_DUMP} state_t;

    localparam logic [PT_W-1:0] LAST_PT = PT_W'(POINTS - 1);

    state_t state, state_n;

    logic [NMEAS_W-1:0]  nmeas_lat;
    logic [NMEAS_W:0]    meas_inc;
    logic                more_traces;

    logic [CH*ACC_W-1:0] mem [0:POINTS-1];
    logic [PT_W-1:0]     rd_addr;
    logic [CH*ACC_W-1:0] rd_p1;
    logic                wr_vld_p1;
    logic                first_p1;
    logic [PT_W-1:0]     addr_p1;
    logic [CH*DATA_W-1:0] data_p1;
    logic [CH*ACC_W-1:0] sum_p1;
    logic [ACC_W-1:0]    base;

    logic [PT_W-1:0]     dump_ptr;
    logic                dump_done;
    logic                dump_issue;
    logic                dvld_p1;
    logic [PT_W-1:0]     dpt_p1;
    logic [1:0]          fifo_cnt;
    logic [2:0]          occ;
    logic [CH*ACC_W-1:0] slot0_q, slot1_q;
    logic [PT_W-1:0]     slot0_pt, slot1_pt;
    logic                push, pop, last_pop;

`ifdef RAMAN_ACC_SATURATE_EN
    logic                clamp_p1;
    logic                lane_clamp;

    function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] acc,
                                                 input logic [DATA_W-1:0] smp,
                                                 output logic clamp);
        logic [ACC_W:0] s;
        s     = {1'b0, acc} + (ACC_W+1)'(smp);
        clamp = s[ACC_W];
        return clamp ? {ACC_W{1'b1}} : s[ACC_W-1:0];
    endfunction
`else
    function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] acc,
                                                 input logic [DATA_W-1:0] smp);
        return acc + ACC_W'(smp);
    endfunction
`endif

    assign meas_inc    = {1'b0, cnt_measure} + {{NMEAS_W{1'b0}}, 1'b1};
    assign more_traces = (meas_inc < {1'b0, nmeas_lat});

    // One shared read port: DUMP walks dump_ptr, otherwise the capture index.
    assign rd_addr = (state == S_DUMP) ? dump_ptr : cnt_point;

    assign q_valid  = (fifo_cnt != 2'd0);
    assign pop      = q_valid && q_ready;
    assign push     = dvld_p1;
    assign last_pop = pop && (slot0_pt == LAST_PT);

    // A read issued now lands in the buffer next cycle; issue only if that
    // entry is guaranteed a slot even when the consumer stalls.
    assign occ        = {1'b0, fifo_cnt} + {2'b00, dvld_p1} - {2'b00, pop};
    assign dump_issue = (state == S_DUMP) && !dump_done && (occ <= 3'd1);

    assign busy    = (state != S_IDLE);
    assign q       = q_valid ? slot0_q  : '0;
    assign q_point = q_valid ? slot0_pt : '0;
    assign q_last  = q_valid && (slot0_pt == LAST_PT);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (start) state_n = S_ARM;
            S_ARM:  if (enable) state_n = S_ACQ;
            S_ACQ:  if (cnt_point == LAST_PT) state_n = S_WB;
            S_WB:   state_n = more_traces ? S_ARM : S_DUMP;
            S_DUMP: if (last_pop) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            nmeas_lat   <= '0;
            cnt_measure <= '0;
            cnt_point   <= '0;
            trig_miss   <= 1'b0;
            ready       <= 1'b0;
            wr_vld_p1   <= 1'b0;
            dvld_p1     <= 1'b0;
            dump_ptr    <= '0;
            dump_done   <= 1'b0;
            fifo_cnt    <= 2'd0;
        end else begin
            ready     <= (state == S_DUMP) && last_pop;
            wr_vld_p1 <= (state == S_ACQ);
            dvld_p1   <= dump_issue;
            fifo_cnt  <= fifo_cnt + {1'b0, push} - {1'b0, pop};
            case (state)
                S_IDLE: begin
                    if (start) begin
                        nmeas_lat   <= (n_meas == '0) ? NMEAS_W'(1) : n_meas;
                        cnt_measure <= '0;
                        trig_miss   <= 1'b0;
                    end
                end
                S_ACQ: begin
                    cnt_point <= (cnt_point == LAST_PT) ? '0 : cnt_point + 1'b1;
                    if (enable) trig_miss <= 1'b1;
                end
                S_WB: begin
                    cnt_measure <= meas_inc[NMEAS_W-1:0];
                    if (!more_traces) begin
                        dump_ptr  <= '0;
                        dump_done <= 1'b0;
                    end
                end
                S_DUMP: begin
                    if (dump_issue) begin
                        if (dump_ptr == LAST_PT) dump_done <= 1'b1;
                        else                     dump_ptr  <= dump_ptr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Stage p0 -> p1: capture sample and issue the RAM read
    always_ff @(posedge clk) begin
        rd_p1    <= mem[rd_addr];
        addr_p1  <= cnt_point;
        data_p1  <= data;
        first_p1 <= (cnt_measure == '0);
        dpt_p1   <= dump_ptr;
    end

    // Stage p1: add (trace 0 ignores the stale RAM word) and write back
    always_comb begin
        sum_p1 = '0;
        base   = '0;
`ifdef RAMAN_ACC_SATURATE_EN
        clamp_p1   = 1'b0;
        lane_clamp = 1'b0;
`endif
        for (int c = 0; c < CH; c++) begin
            base = first_p1 ? '0 : rd_p1[c*ACC_W +: ACC_W];
`ifdef RAMAN_ACC_SATURATE_EN
            sum_p1[c*ACC_W +: ACC_W] = acc_add(base, data_p1[c*DATA_W +: DATA_W], lane_clamp);
            clamp_p1 = clamp_p1 | lane_clamp;
`else
            sum_p1[c*ACC_W +: ACC_W] = acc_add(base, data_p1[c*DATA_W +: DATA_W]);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (wr_vld_p1) mem[addr_p1] <= sum_p1;
    end

`ifdef RAMAN_ACC_SATURATE_EN
    always_ff @(posedge clk) begin
        if (rst)                            sat_flag <= 1'b0;
        else if (state == S_IDLE && start)  sat_flag <= 1'b0;
        else if (wr_vld_p1 && clamp_p1)     sat_flag <= 1'b1;
    end
`else
    assign sat_flag = 1'b0;
`endif

    // Stage p1 -> p2: readout skid buffer, slot0 is the presented head
    always_ff @(posedge clk) begin
        case ({push, pop})
            2'b10: begin
                if (fifo_cnt == 2'd0) begin
                    slot0_q <= rd_p1; slot0_pt <= dpt_p1;
                end else begin
                    slot1_q <= rd_p1; slot1_pt <= dpt_p1;
                end
            end
            2'b01: begin
                slot0_q <= slot1_q; slot0_pt <= slot1_pt;
            end
            2'b11: begin
                if (fifo_cnt == 2'd2) begin
                    slot0_q <= slot1_q; slot0_pt <= slot1_pt;
                    slot1_q <= rd_p1;   slot1_pt <= dpt_p1;
                end else begin
                    slot0_q <= rd_p1;   slot0_pt <= dpt_p1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_raman_trace_accum.sv
module tb_raman_trace_accum;

    localparam int DATA_W  = 12;
    localparam int CH      = 2;
    localparam int POINTS  = 10;
    localparam int ACC_W   = 13;
    localparam int NMEAS_W = 17;
    localparam int PT_W    = 4;
    localparam int ACC_MOD = 1 << ACC_W;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [NMEAS_W-1:0]    n_meas;
    logic                  enable;
    logic [CH*DATA_W-1:0]  data;
    logic                  busy, ready;
    logic [NMEAS_W-1:0]    cnt_measure;
    logic [PT_W-1:0]       cnt_point;
    logic                  trig_miss;
    logic [CH*ACC_W-1:0]   q;
    logic                  q_valid;
    logic                  q_ready;
    logic [PT_W-1:0]       q_point;
    logic                  q_last;
    logic                  sat_flag;

    raman_trace_accum #(
        .DATA_W(DATA_W), .CH(CH), .POINTS(POINTS), .ACC_W(ACC_W),
        .NMEAS_W(NMEAS_W), .PT_W(PT_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .n_meas(n_meas), .enable(enable),
        .data(data), .busy(busy), .ready(ready), .cnt_measure(cnt_measure),
        .cnt_point(cnt_point), .trig_miss(trig_miss), .q(q), .q_valid(q_valid),
        .q_ready(q_ready), .q_point(q_point), .q_last(q_last), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference model: per-point, per-channel running sums
    int  model_acc [POINTS][CH];
    bit  model_sat;
    bit  model_miss;

    typedef struct {
        logic [CH*ACC_W-1:0] qv;
        int                  pt;
    } exp_t;
    exp_t sb[$];

    function automatic logic [CH*DATA_W-1:0] gen(input int mode, input int j, input int k);
        int v0, v1;
        case (mode)
            0:       begin v0 = 100 * j;       v1 = 5; end
            1:       begin v0 = 100 * (j + k); v1 = int'($urandom % 4096); end
            2:       begin v0 = int'($urandom % 4096); v1 = int'($urandom % 4096); end
            default: begin v0 = 4095; v1 = 4095; end
        endcase
        return {DATA_W'(v1), DATA_W'(v0)};
    endfunction

    task automatic model_update(input int j, input int k, input logic [CH*DATA_W-1:0] d);
        int s;
        for (int c = 0; c < CH; c++) begin
            s = int'(d[c*DATA_W +: DATA_W]);
            if (k != 0) s = s + model_acc[j][c];
`ifdef RAMAN_ACC_SATURATE_EN
            if (s >= ACC_MOD) begin
                s = ACC_MOD - 1;
                model_sat = 1'b1;
            end
`else
            s = s % ACC_MOD;
`endif
            model_acc[j][c] = s;
        end
    endtask

    task automatic push_expected();
        exp_t e;
        for (int j = 0; j < POINTS; j++) begin
            e.qv = '0;
            for (int c = 0; c < CH; c++) e.qv[c*ACC_W +: ACC_W] = ACC_W'(model_acc[j][c]);
            e.pt = j;
            sb.push_back(e);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake, checks stall stability
    logic [CH*ACC_W-1:0] prev_q;
    logic [PT_W-1:0]     prev_pt;
    bit                  prev_stall = 1'b0;
    int                  ready_pulses = 0;
    exp_t                mon_e;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", q_valid, 1);
                check("stall_q", q, prev_q);
                check("stall_point", q_point, prev_pt);
            end
            if (q_valid && q_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_output: point %0d presented, expected nothing", q_point);
                end else begin
                    mon_e = sb.pop_front();
                    check("q", q, mon_e.qv);
                    check("q_point", q_point, mon_e.pt);
                    check("q_last", q_last, (mon_e.pt == POINTS - 1) ? 1 : 0);
                end
            end
            prev_stall = q_valid && !q_ready;
            prev_q     = q;
            prev_pt    = q_point;
            if (ready) ready_pulses++;
        end
    end

    // Consumer: 0 = always ready, 1 = pattern 1,0,0,..., 2 = random
    int rdy_mode = 0;
    int tog = 0;
    initial begin
        q_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: q_ready = 1'b1;
                1: begin q_ready = (tog % 3 == 0); tog++; end
                default: q_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_ready"}, ready, 0);
        check({tag, "_cnt_measure"}, cnt_measure, 0);
        check({tag, "_cnt_point"}, cnt_point, 0);
        check({tag, "_trig_miss"}, trig_miss, 0);
        check({tag, "_q"}, q, 0);
        check({tag, "_q_valid"}, q_valid, 0);
        check({tag, "_q_point"}, q_point, 0);
        check({tag, "_q_last"}, q_last, 0);
        check({tag, "_sat_flag"}, sat_flag, 0);
    endtask

    task automatic do_start(input int nm, input bit with_en);
        start  = 1'b1;
        n_meas = NMEAS_W'(nm);
        enable = with_en;
        tick();
        start  = 1'b0;
        enable = 1'b0;
        check("busy_after_start", busy, 1);
        check("cnt_measure_start", cnt_measure, 0);
        check("trig_miss_start", trig_miss, 0);
        check("sat_flag_start", sat_flag, 0);
        model_sat    = 1'b0;
        model_miss   = 1'b0;
        ready_pulses = 0;
    endtask

    // Entered in ARM; captures stop_at points (a full trace also sees WB)
    task automatic run_trace(input int k, input int mode, input int miss_at,
                             input int stop_at, input bit bogus_start);
        enable = 1'b1;
        tick();
        enable = 1'b0;
        for (int j = 0; j < stop_at; j++) begin
            data   = gen(mode, j, k);
            enable = (j == miss_at);
            start  = bogus_start && (j == 2);
            n_meas = bogus_start ? NMEAS_W'(3) : n_meas;
            check("cnt_point", cnt_point, j);
            model_update(j, k, data);
            if (j == miss_at) model_miss = 1'b1;
            tick();
        end
        enable = 1'b0;
        start  = 1'b0;
        if (stop_at == POINTS) begin
            tick();
            check("cnt_measure", cnt_measure, k + 1);
        end
    endtask

    task automatic run_seq(input int nm, input int mode, input int rmode, input bit lat_chk,
                           input int miss_trace, input bit start_en, input int bogus_trace);
        int nm_eff;
        int cyc;
        nm_eff   = (nm == 0) ? 1 : nm;
        rdy_mode = rmode;
        tog      = 0;
        do_start(nm, start_en);
        for (int k = 0; k < nm_eff; k++) begin
            run_trace(k, mode, (k == miss_trace) ? 4 : -1, POINTS, (k == bogus_trace));
            if (k < nm_eff - 1) repeat ($urandom_range(0, 2)) tick();
        end
        push_expected();
        if (lat_chk) begin
            check("q_valid_dump_d0", q_valid, 0);
            tick();
            check("q_valid_dump_d1", q_valid, 0);
            tick();
            check("q_valid_dump_d2", q_valid, 1);
        end
        cyc = 0;
        while (!ready && cyc < 400) begin
            tick();
            cyc++;
        end
        check("ready_seen", ready, 1);
        check("busy_at_ready", busy, 0);
        tick();
        tick();
        check("ready_pulses", ready_pulses, 1);
        check("sb_drained", sb.size(), 0);
        check("cnt_measure_final", cnt_measure, nm_eff);
        check("trig_miss_final", trig_miss, model_miss);
        check("sat_flag_final", sat_flag, model_sat);
        check("busy_idle", busy, 0);
        sb.delete();
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        n_meas = '0;
        enable = 1'b0;
        data   = '0;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Single trace, ramp on ch0 and constant on ch1, DUMP latency checked
        run_seq(1, 0, 0, 1, -1, 0, -1);
        // Twelve traces, start pulsed mid-acquisition must be ignored
        run_seq(12, 1, 0, 0, -1, 0, 1);
        // Start together with enable, then a missed trigger in trace 0
        run_seq(1, 0, 0, 0, 0, 1, -1);
        // Back-pressured readout
        run_seq(3, 2, 1, 0, -1, 0, -1);

        // Reset in the middle of trace 3, then a fresh 2-trace sequence
        rdy_mode = 0;
        do_start(5, 0);
        for (int k = 0; k < 3; k++) run_trace(k, 2, -1, POINTS, 0);
        run_trace(3, 2, -1, 4, 0);
        rst = 1'b1;
        tick();
        check_all_zero("midrst");
        tick();
        rst = 1'b0;
        tick();
        run_seq(2, 2, 2, 0, -1, 0, -1);

        // Full-scale data over three traces: clamps or wraps
        run_seq(3, 3, 0, 0, -1, 0, -1);
        // n_meas of zero behaves as one
        run_seq(0, 2, 2, 0, -1, 0, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
